ureg_pet_asyn_al_mode: RTL and testbench
========================================

# ureg_pet_asyn_al_mode

Parametrised universal register for the flip-flop library: a WIDTH-bit positive-edge register with asynchronous active-low reset, clock enable and a 3-bit mode select. Modes cover hold, parallel load, synchronous set/clear, shift left/right and increment/decrement. It supersedes the single-bit enable/load flip-flops wherever a datapath needs a loadable, shiftable or counting register.

## Interface
- WIDTH, 8, register width in bits (≥ 2)
- RESET_VAL, {WIDTH{1'b0}}, value forced by reset
- clk  input  1  clock, rising-edge active
- reset_al_in  input  1  reset, asynchronous, active-low; clock clk
- en_in  input  1  clock enable; low = hold regardless of mode
- mode_in  input  3  operation select (see Operation)
- d_in  input  WIDTH  parallel load data
- ser_l_in  input  1  serial bit shifted into bit 0 on SHL
- ser_r_in  input  1  serial bit shifted into bit WIDTH-1 on SHR
- q_out  output  WIDTH  register contents
- flag_out  output  1  registered carry/borrow/shift-out bit
- zero_out  output  1  combinational, high when q_out == 0

## Operation
- Priority: reset_al_in low > en_in low (hold q_out and flag_out) > mode_in.
- Mode encoding (next q_out / next flag_out):
  - 000 HOLD: q / flag unchanged
  - 001 LOAD: d_in / 0
  - 010 SET: all ones / 0
  - 011 CLR: all zeros / 0
  - 100 SHL: {q[WIDTH-2:0], ser_l_in} / q[WIDTH-1]
  - 101 SHR: {ser_r_in, q[WIDTH-1:1]} / q[0]
  - 110 INC: q+1 modulo 2^WIDTH / 1 iff q was all ones (wrap)
  - 111 DEC: q-1 modulo 2^WIDTH / 1 iff q was zero (underflow)
- Arithmetic: WIDTH+1-bit internal sum; the extra bit becomes flag_out. No saturation.
- flag_out is sticky only through HOLD or en_in low; every other mode rewrites it.
- zero_out is derived from q_out only; it is never registered.

## Timing
- Reset: q_out = RESET_VAL and flag_out = 0 immediately on reset_al_in falling, independent of clk; held while low.
- Reset release: the first rising clk edge with reset_al_in high applies the mode. Release coincident with an edge makes that edge a no-op.
- Latency: one cycle; q_out and flag_out update on the same rising edge, and zero_out follows combinationally.
- mode_in, en_in, d_in and the serial inputs are sampled only at the rising edge. No handshake, and no multi-cycle operations.
- Reset asserted mid-sequence (e.g. during a count) aborts at once; no partial state survives.

## Configuration
- UREG_ROTATE_EN defined: SHL feeds q[WIDTH-1] into bit 0 and SHR feeds q[0] into bit WIDTH-1. ser_l_in and ser_r_in are ignored, and flag_out still takes the bit rotated across the boundary.
- Undefined (default): SHL and SHR take ser_l_in and ser_r_in as listed above.
- All other modes are identical in both builds.

## Structure
- Shared package ff_lib_pkg holds the mode constants (UREG_HOLD … UREG_DEC, 3 bits) so that controllers driving mode_in use the same encoding.
- One sub-module is natural: ureg_next, a purely combinational next-state/flag generator (mode, q, d, serial bits → next q, next flag). The top holds only the async-reset register and enable mux.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5, pulse reset_al_in low between edges → q_out=8'hA5 and flag_out=0 with no clock edge; zero_out=0.
- Load/enable: LOAD d_in=8'h3C with en_in=1 → q_out=8'h3C next edge; then en_in=0 with mode SET → q_out stays 8'h3C.
- Count wrap: load 8'hFE, INC for two edges → 8'hFF with flag 0, then 8'h00 with flag 1 and zero_out=1. Then DEC → 8'hFF with flag 1.
- Shift (macro off): load 8'h81, SHL with ser_l_in=0 → 8'h02, flag 1; then SHR with ser_r_in=1 → 8'h81, flag 0.
- Rotate (UREG_ROTATE_EN): load 8'h81, SHL → 8'h03, flag 1; SHR → 8'h81, flag 1.
- Mid-operation reset: INC running from 8'h10, assert reset_al_in after three edges → q_out=RESET_VAL at once. Release coincident with an edge → no increment on that edge.

Source files
------------

// File: rtl/ff_lib_pkg.sv
// Shared flip-flop library definitions: universal register mode encoding.
// Controllers driving mode_in import this package so both sides agree on the codes.
package ff_lib_pkg;

    typedef enum logic [2:0] {
        UREG_HOLD = 3'b000,
        UREG_LOAD = 3'b001,
        UREG_SET  = 3'b010,
        UREG_CLR  = 3'b011,
        UREG_SHL  = 3'b100,
        UREG_SHR  = 3'b101,
        UREG_INC  = 3'b110,
        UREG_DEC  = 3'b111
    } ureg_mode_e;

    localparam int unsigned UREG_MODE_W = 3;

endpackage

// File: rtl/ureg_next.sv
// Combinational next-state / flag generator for the universal register.
// UREG_ROTATE_EN: shifts rotate through the register instead of taking serial inputs.
module ureg_next
    import ff_lib_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [UREG_MODE_W-1:0] mode_in,
    input  logic [WIDTH-1:0]       q_in,
    input  logic                   flag_in,
    input  logic [WIDTH-1:0]       d_in,
    input  logic                   ser_l_in,
    input  logic                   ser_r_in,
    output logic [WIDTH-1:0]       q_nxt_out,
    output logic                   flag_nxt_out
);

    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;
    logic           w_shl_bit;
    logic           w_shr_bit;

    // Extra MSB carries the wrap/borrow out of the WIDTH-bit result.
    assign w_inc = {1'b0, q_in} + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec = {1'b0, q_in} - {{WIDTH{1'b0}}, 1'b1};

`ifdef UREG_ROTATE_EN
    assign w_shl_bit = q_in[WIDTH-1];
    assign w_shr_bit = q_in[0];
`else
    assign w_shl_bit = ser_l_in;
    assign w_shr_bit = ser_r_in;
`endif

    always_comb begin
        q_nxt_out    = q_in;
        flag_nxt_out = flag_in;
        case (ureg_mode_e'(mode_in))
            UREG_HOLD: begin
                q_nxt_out    = q_in;
                flag_nxt_out = flag_in;
            end
            UREG_LOAD: begin
                q_nxt_out    = d_in;
                flag_nxt_out = 1'b0;
            end
            UREG_SET: begin
                q_nxt_out    = '1;
                flag_nxt_out = 1'b0;
            end
            UREG_CLR: begin
                q_nxt_out    = '0;
                flag_nxt_out = 1'b0;
            end
            UREG_SHL: begin
                q_nxt_out    = {q_in[WIDTH-2:0], w_shl_bit};
                flag_nxt_out = q_in[WIDTH-1];
            end
            UREG_SHR: begin
                q_nxt_out    = {w_shr_bit, q_in[WIDTH-1:1]};
                flag_nxt_out = q_in[0];
            end
            UREG_INC: begin
                q_nxt_out    = w_inc[WIDTH-1:0];
                flag_nxt_out = w_inc[WIDTH];
            end
            UREG_DEC: begin
                q_nxt_out    = w_dec[WIDTH-1:0];
                flag_nxt_out = w_dec[WIDTH];
            end
            default: begin
                q_nxt_out    = q_in;
                flag_nxt_out = flag_in;
            end
        endcase
    end

endmodule

// File: rtl/ureg_pet_asyn_al_mode.sv
// Universal register: async active-low reset, clock enable, 3-bit mode select.
// Build option UREG_ROTATE_EN (see ureg_next) turns SHL/SHR into rotates.
module ureg_pet_asyn_al_mode
    import ff_lib_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset_al_in,
    input  logic                   en_in,
    input  logic [UREG_MODE_W-1:0] mode_in,
    input  logic [WIDTH-1:0]       d_in,
    input  logic                   ser_l_in,
    input  logic                   ser_r_in,
    output logic [WIDTH-1:0]       q_out,
    output logic                   flag_out,
    output logic                   zero_out
);

    logic [WIDTH-1:0] r_q;
    logic             r_flag;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_flag_nxt;

    ureg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .mode_in      (mode_in),
        .q_in         (r_q),
        .flag_in      (r_flag),
        .d_in         (d_in),
        .ser_l_in     (ser_l_in),
        .ser_r_in     (ser_r_in),
        .q_nxt_out    (w_q_nxt),
        .flag_nxt_out (w_flag_nxt)
    );

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            r_q    <= RESET_VAL;
            r_flag <= 1'b0;
        end else if (en_in) begin
            r_q    <= w_q_nxt;
            r_flag <= w_flag_nxt;
        end
    end

    assign q_out    = r_q;
    assign flag_out = r_flag;
    assign zero_out = (r_q == '0);

endmodule

// File: tb/tb_ureg_pet_asyn_al_mode.sv
// Directed self-checking bench for ureg_pet_asyn_al_mode (WIDTH=8, RESET_VAL=8'hA5).
// Shift expectations follow the UREG_ROTATE_EN build option.
module tb_ureg_pet_asyn_al_mode;
    import ff_lib_pkg::*;

    logic       clk;
    logic       reset_al_in;
    logic       en_in;
    logic [2:0] mode_in;
    logic [7:0] d_in;
    logic       ser_l_in;
    logic       ser_r_in;
    logic [7:0] q_out;
    logic       flag_out;
    logic       zero_out;

    int unsigned n_pass;
    int unsigned n_total;

    ureg_pet_asyn_al_mode #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .en_in       (en_in),
        .mode_in     (mode_in),
        .d_in        (d_in),
        .ser_l_in    (ser_l_in),
        .ser_r_in    (ser_r_in),
        .q_out       (q_out),
        .flag_out    (flag_out),
        .zero_out    (zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic check_state(input string tag, input logic [7:0] q, input logic f, input logic z);
        check({tag, ".q"}, 32'(q_out), 32'(q));
        check({tag, ".flag"}, 32'(flag_out), 32'(f));
        check({tag, ".zero"}, 32'(zero_out), 32'(z));
    endtask

    task automatic step(input logic [2:0] m, input logic e, input logic [7:0] d,
                        input logic sl, input logic sr);
        @(negedge clk);
        mode_in  = m;
        en_in    = e;
        d_in     = d;
        ser_l_in = sl;
        ser_r_in = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset_al_in = 1'b1;
        en_in       = 1'b0;
        mode_in     = UREG_HOLD;
        d_in        = '0;
        ser_l_in    = 1'b0;
        ser_r_in    = 1'b0;

        // async reset with no clock edge in between
        #2 reset_al_in = 1'b0;
        #1 check_state("reset", 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        reset_al_in = 1'b1;

        step(UREG_LOAD, 1'b1, 8'h3C, 1'b0, 1'b0);
        check_state("load", 8'h3C, 1'b0, 1'b0);
        step(UREG_SET, 1'b0, 8'h00, 1'b0, 1'b0);
        check_state("en_low", 8'h3C, 1'b0, 1'b0);
        step(UREG_SET, 1'b1, 8'h00, 1'b0, 1'b0);
        check_state("set", 8'hFF, 1'b0, 1'b0);
        step(UREG_CLR, 1'b1, 8'h00, 1'b0, 1'b0);
        check_state("clr", 8'h00, 1'b0, 1'b1);

        step(UREG_LOAD, 1'b1, 8'hFE, 1'b0, 1'b0);
        step(UREG_INC, 1'b1, 8'h00, 1'b0, 1'b0);
        check_state("inc1", 8'hFF, 1'b0, 1'b0);
        step(UREG_INC, 1'b1, 8'h00, 1'b0, 1'b0);
        check_state("inc_wrap", 8'h00, 1'b1, 1'b1);
        step(UREG_HOLD, 1'b1, 8'h00, 1'b0, 1'b0);
        check_state("hold_sticky", 8'h00, 1'b1, 1'b1);
        step(UREG_DEC, 1'b0, 8'h00, 1'b0, 1'b0);
        check_state("en_low_sticky", 8'h00, 1'b1, 1'b1);
        step(UREG_DEC, 1'b1, 8'h00, 1'b0, 1'b0);
        check_state("dec_under", 8'hFF, 1'b1, 1'b0);
        step(UREG_DEC, 1'b1, 8'h00, 1'b0, 1'b0);
        check_state("dec", 8'hFE, 1'b0, 1'b0);

        step(UREG_LOAD, 1'b1, 8'h81, 1'b0, 1'b0);
        check_state("load81", 8'h81, 1'b0, 1'b0);
        step(UREG_SHL, 1'b1, 8'h00, 1'b0, 1'b0);
`ifdef UREG_ROTATE_EN
        check_state("shl", 8'h03, 1'b1, 1'b0);
`else
        check_state("shl", 8'h02, 1'b1, 1'b0);
`endif
        step(UREG_SHR, 1'b1, 8'h00, 1'b0, 1'b1);
`ifdef UREG_ROTATE_EN
        check_state("shr", 8'h81, 1'b1, 1'b0);
`else
        check_state("shr", 8'h81, 1'b0, 1'b0);
`endif
        step(UREG_LOAD, 1'b1, 8'h40, 1'b0, 1'b0);
        step(UREG_SHL, 1'b1, 8'h00, 1'b1, 1'b0);
`ifdef UREG_ROTATE_EN
        check_state("shl_ser1", 8'h80, 1'b0, 1'b0);
`else
        check_state("shl_ser1", 8'h81, 1'b0, 1'b0);
`endif

        step(UREG_LOAD, 1'b1, 8'h10, 1'b0, 1'b0);
        step(UREG_INC, 1'b1, 8'h00, 1'b0, 1'b0);
        step(UREG_INC, 1'b1, 8'h00, 1'b0, 1'b0);
        step(UREG_INC, 1'b1, 8'h00, 1'b0, 1'b0);
        check_state("count3", 8'h13, 1'b0, 1'b0);
        #2 reset_al_in = 1'b0;
        #1 check_state("mid_reset", 8'hA5, 1'b0, 1'b0);
        // nonblocking so the release lands after the DUT has seen this edge
        @(posedge clk);
        reset_al_in <= 1'b1;
        #1 check_state("release_edge", 8'hA5, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_state("post_release", 8'hA6, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
